rr_vc_arb_lock: RTL

RR_VC_ARB_LOCK -- requirements
Module: rr_vc_arb_lock

---
 rtl/rr_vc_arb_lock.sv | 114 +++++++++++
 1 files changed

// File: rtl/rr_vc_arb_lock.sv
// Per-VN round-robin VC arbiter with optional grant locking; 1-cycle registered grant.
// Backpressure: a VN grants only while avail_i is high; a locked grant is held until its release strobe.
module rr_vc_arb_lock #(
    parameter  int NUM_VC      = 4,
    parameter  int NUM_VN      = 3,
    parameter  int LOCK_EN     = 1,
    localparam int bits_VC     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int NUM_VN_X_VC = NUM_VC * NUM_VN
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_VN_X_VC-1:0]      req_i,
    input  logic [NUM_VN_X_VC-1:0]      release_i,
    input  logic [NUM_VN-1:0]           avail_i,
    output logic [NUM_VN_X_VC-1:0]      grant_o,
    output logic [NUM_VN-1:0]           grant_vld_o,
    output logic [NUM_VN*bits_VC-1:0]   grant_id_o
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    for (genvar vn = 0; vn < NUM_VN; vn++) begin : g_vn
        logic [NUM_VC-1:0]  req_vn;
        logic [NUM_VC-1:0]  rel_vn;
        logic [NUM_VC-1:0]  grant_q, grant_d;
        logic [bits_VC-1:0] ptr_q, ptr_d;
        logic [bits_VC-1:0] id_q, id_d;
        logic [bits_VC-1:0] win;
        logic               vld_q, vld_d;
        logic               any_req;
        logic               rel_hit;
        logic [0:0]         state_q, state_d;

        assign req_vn  = req_i[vn*NUM_VC +: NUM_VC];
        assign rel_vn  = release_i[vn*NUM_VC +: NUM_VC];
        assign rel_hit = |(rel_vn & grant_q);

        // Scan VCs starting at ptr, wrapping modulo NUM_VC so non-power-of-two sizes stay in range.
        always_comb begin : arb
            int               idx;
            logic [bits_VC-1:0] idx_w;
            any_req = 1'b0;
            win     = '0;
            idx     = 0;
            idx_w   = '0;
            for (int i = 0; i < NUM_VC; i++) begin
                idx = int'(ptr_q) + i;
                if (idx >= NUM_VC) begin
                    idx = idx - NUM_VC;
                end
                idx_w = bits_VC'(idx);
                if (!any_req && req_vn[idx_w]) begin
                    any_req = 1'b1;
                    win     = idx_w;
                end
            end
        end

        always_comb begin : nxt
            state_d = state_q;
            ptr_d   = ptr_q;
            grant_d = grant_q;
            id_d    = id_q;
            vld_d   = vld_q;
            case (state_q)
                LOCKED: begin
                    if (rel_hit) begin
                        state_d = IDLE;
                        grant_d = '0;
                        id_d    = '0;
                        vld_d   = 1'b0;
                    end
                end
                default: begin
                    if (avail_i[vn] && any_req) begin
                        grant_d      = '0;
                        grant_d[win] = 1'b1;
                        id_d         = win;
                        vld_d        = 1'b1;
                        ptr_d        = (int'(win) == NUM_VC - 1) ? '0 : win + 1'b1;
                        state_d      = (LOCK_EN != 0) ? LOCKED : IDLE;
                    end else begin
                        grant_d = '0;
                        id_d    = '0;
                        vld_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= IDLE;
                ptr_q   <= '0;
                grant_q <= '0;
                id_q    <= '0;
                vld_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                ptr_q   <= ptr_d;
                grant_q <= grant_d;
                id_q    <= id_d;
                vld_q   <= vld_d;
            end
        end

        assign grant_o[vn*NUM_VC +: NUM_VC]     = grant_q;
        assign grant_vld_o[vn]                  = vld_q;
        assign grant_id_o[vn*bits_VC +: bits_VC] = id_q;
    end

endmodule
